ycbcr2rgb: RTL and testbench

//  Converts a pipelined Y/Cb/Cr 4:4:4 pixel stream (8b each) back to 8b RGB for display output.

---
 rtl/ycbcr_pkg.sv | 35 +++
 rtl/ycbcr2rgb_chan.sv | 80 ++++++++
 rtl/ycbcr2rgb.sv | 165 ++++++++++++++++
 tb/tb_ycbcr2rgb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ycbcr_pkg.sv
// rtl/ycbcr_pkg.sv - shared widths, BT.601 default coefficients and coefficient-set types for ycbcr2rgb
package ycbcr_pkg;

  localparam int PIX_W         = 8;
  localparam int COEF_W        = 18;
  localparam int CHROMA_OFS    = 128;
  localparam int DIFF_W        = PIX_W + 1;
  localparam int PROD_W        = 27;
  localparam int SUM_W         = 29;
  localparam int COEF_FRAC_DEF = 16;

  // BT.601 full-range inverse coefficients in Q1.16
  localparam int KRCR_BT601 = 91881;
  localparam int KGCB_BT601 = -22553;
  localparam int KGCR_BT601 = -46802;
  localparam int KBCB_BT601 = 116130;

  typedef enum logic {
    COEF_IDLE = 1'b0,
    COEF_PEND = 1'b1
  } coef_state_e;

  typedef struct packed {
    logic signed [COEF_W-1:0] kr_cr;
    logic signed [COEF_W-1:0] kg_cb;
    logic signed [COEF_W-1:0] kg_cr;
    logic signed [COEF_W-1:0] kb_cb;
  } coef_set_t;

  // Offset-binary chroma to signed two's complement difference (range -128..127)
  function automatic logic signed [DIFF_W-1:0] chroma_diff(input logic [PIX_W-1:0] c);
    return DIFF_W'({1'b0, c}) - DIFF_W'(CHROMA_OFS);
  endfunction

endpackage

// File: rtl/ycbcr2rgb_chan.sv
// rtl/ycbcr2rgb_chan.sv - one output channel: Y plus two coefficient products, optional rounding (YCBCR2RGB_ROUND_EN), saturation
module ycbcr2rgb_chan
  import ycbcr_pkg::*;
#(
  parameter int COEF_FRAC = COEF_FRAC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic        [PIX_W-1:0]  y_i,
  input  logic signed [DIFF_W-1:0] d0_i,
  input  logic signed [DIFF_W-1:0] d1_i,
  input  logic signed [COEF_W-1:0] k0_i,
  input  logic signed [COEF_W-1:0] k1_i,
  output logic        [PIX_W-1:0]  pix_o
);

  // Only the integer part of the sum (plus sign) is kept past S3
  localparam int HI_W = SUM_W - COEF_FRAC;

`ifdef YCBCR2RGB_ROUND_EN
  localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) <<< (COEF_FRAC - 1);
`else
  localparam logic signed [SUM_W-1:0] RND = '0;
`endif

  logic        [PIX_W-1:0]  y2_d,  y2_q;
  logic signed [PROD_W-1:0] p0_d,  p0_q;
  logic signed [PROD_W-1:0] p1_d,  p1_q;
  logic signed [SUM_W-1:0]  y_ext, p0_ext, p1_ext;
  logic signed [HI_W-1:0]   sum_d, sum_q;
  logic        [PIX_W-1:0]  pix_d, pix_q;

  // S2: 9x18 signed products, operands sign-extended to the product width
  always_comb begin
    y2_d = y_i;
    p0_d = $signed({{(PROD_W-DIFF_W){d0_i[DIFF_W-1]}}, d0_i})
         * $signed({{(PROD_W-COEF_W){k0_i[COEF_W-1]}}, k0_i});
    p1_d = $signed({{(PROD_W-DIFF_W){d1_i[DIFF_W-1]}}, d1_i})
         * $signed({{(PROD_W-COEF_W){k1_i[COEF_W-1]}}, k1_i});
  end

  // S3: align Y to the coefficient binary point, accumulate, keep integer part
  always_comb begin
    y_ext  = $signed({{(SUM_W-PIX_W-COEF_FRAC){1'b0}}, y2_q, {COEF_FRAC{1'b0}}});
    p0_ext = $signed({{(SUM_W-PROD_W){p0_q[PROD_W-1]}}, p0_q});
    p1_ext = $signed({{(SUM_W-PROD_W){p1_q[PROD_W-1]}}, p1_q});
    sum_d  = HI_W'((y_ext + p0_ext + p1_ext + RND) >>> COEF_FRAC);
  end

  // S4: clamp to 0..255
  always_comb begin
    if (sum_q[HI_W-1]) begin
      pix_d = '0;
    end else if (sum_q[HI_W-2:PIX_W] != '0) begin
      pix_d = '1;
    end else begin
      pix_d = sum_q[PIX_W-1:0];
    end
  end

  // Data stages are don't-care after reset; only the visible output is cleared
  always_ff @(posedge clk) begin
    y2_q  <= y2_d;
    p0_q  <= p0_d;
    p1_q  <= p1_d;
    sum_q <= sum_d;
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_d;
    end
  end

  assign pix_o = pix_q;

endmodule

// File: rtl/ycbcr2rgb.sv
// rtl/ycbcr2rgb.sv - Y/Cb/Cr to RGB, latency 4, frame-synchronous coefficient update; YCBCR2RGB_ROUND_EN selects rounding
module ycbcr2rgb
  import ycbcr_pkg::*;
#(
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int KRCR_DEF  = KRCR_BT601,
  parameter int KGCB_DEF  = KGCB_BT601,
  parameter int KGCR_DEF  = KGCR_BT601,
  parameter int KBCB_DEF  = KBCB_BT601
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coef_wr_i,
  input  logic signed [COEF_W-1:0] kr_cr_i,
  input  logic signed [COEF_W-1:0] kg_cb_i,
  input  logic signed [COEF_W-1:0] kg_cr_i,
  input  logic signed [COEF_W-1:0] kb_cb_i,
  output logic                     coef_pend_o,
  input  logic                     dv_i,
  input  logic                     hs_i,
  input  logic                     vs_i,
  input  logic        [PIX_W-1:0]  y_i,
  input  logic        [PIX_W-1:0]  cb_i,
  input  logic        [PIX_W-1:0]  cr_i,
  output logic                     dv_o,
  output logic                     hs_o,
  output logic                     vs_o,
  output logic        [PIX_W-1:0]  r_o,
  output logic        [PIX_W-1:0]  g_o,
  output logic        [PIX_W-1:0]  b_o
);

  localparam int LAT = 4;

  localparam coef_set_t DEF_SET = '{
    kr_cr: COEF_W'(KRCR_DEF),
    kg_cb: COEF_W'(KGCB_DEF),
    kg_cr: COEF_W'(KGCR_DEF),
    kb_cb: COEF_W'(KBCB_DEF)
  };

  coef_state_e state_d, state_q;
  coef_set_t   shadow_d, shadow_q;
  coef_set_t   active_d, active_q;
  coef_set_t   wr_set;
  logic        vs_d, vs_q;
  logic        vs_rise;
  logic        xfer;

  logic [LAT-1:0][2:0] ctrl_d, ctrl_q;

  logic        [PIX_W-1:0]  y1_d,   y1_q;
  logic signed [DIFF_W-1:0] dcb1_d, dcb1_q;
  logic signed [DIFF_W-1:0] dcr1_d, dcr1_q;
  coef_set_t                kset1_d, kset1_q;

  // Coefficient FSM: a write always wins over a coincident vsync edge
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    xfer     = 1'b0;
    vs_d     = vs_i;
    vs_rise  = vs_i & ~vs_q;
    wr_set   = '{kr_cr: kr_cr_i, kg_cb: kg_cb_i, kg_cr: kg_cr_i, kb_cb: kb_cb_i};
    case (state_q)
      COEF_IDLE: begin
        if (coef_wr_i) begin
          shadow_d = wr_set;
          state_d  = COEF_PEND;
        end
      end
      COEF_PEND: begin
        if (coef_wr_i) begin
          shadow_d = wr_set;
        end else if (vs_rise) begin
          active_d = shadow_q;
          xfer     = 1'b1;
          state_d  = COEF_IDLE;
        end
      end
      default: state_d = COEF_IDLE;
    endcase
  end

  // Control delay line, matched to the 4-stage datapath
  always_comb begin
    ctrl_d[0] = {dv_i, hs_i, vs_i};
    for (int i = 1; i < LAT; i++) begin
      ctrl_d[i] = ctrl_q[i-1];
    end
  end

  // S1: the pixel in the transfer cycle already picks up the shadow set
  always_comb begin
    y1_d    = y_i;
    dcb1_d  = chroma_diff(cb_i);
    dcr1_d  = chroma_diff(cr_i);
    kset1_d = xfer ? shadow_q : active_q;
  end

  // Control state; vs_q resets high to mask a vsync rise right after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COEF_IDLE;
      shadow_q <= DEF_SET;
      active_q <= DEF_SET;
      vs_q     <= 1'b1;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      vs_q     <= vs_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // S1 data registers, coefficient set travels with the pixel from here
  always_ff @(posedge clk) begin
    y1_q    <= y1_d;
    dcb1_q  <= dcb1_d;
    dcr1_q  <= dcr1_d;
    kset1_q <= kset1_d;
  end

  ycbcr2rgb_chan #(.COEF_FRAC(COEF_FRAC)) u_chan_r (
    .clk   (clk),
    .rst   (rst),
    .y_i   (y1_q),
    .d0_i  (dcr1_q),
    .d1_i  (dcb1_q),
    .k0_i  (kset1_q.kr_cr),
    .k1_i  ('0),
    .pix_o (r_o)
  );

  ycbcr2rgb_chan #(.COEF_FRAC(COEF_FRAC)) u_chan_g (
    .clk   (clk),
    .rst   (rst),
    .y_i   (y1_q),
    .d0_i  (dcb1_q),
    .d1_i  (dcr1_q),
    .k0_i  (kset1_q.kg_cb),
    .k1_i  (kset1_q.kg_cr),
    .pix_o (g_o)
  );

  ycbcr2rgb_chan #(.COEF_FRAC(COEF_FRAC)) u_chan_b (
    .clk   (clk),
    .rst   (rst),
    .y_i   (y1_q),
    .d0_i  (dcb1_q),
    .d1_i  (dcr1_q),
    .k0_i  (kset1_q.kb_cb),
    .k1_i  ('0),
    .pix_o (b_o)
  );

  assign coef_pend_o = (state_q == COEF_PEND);
  assign dv_o        = ctrl_q[LAT-1][2];
  assign hs_o        = ctrl_q[LAT-1][1];
  assign vs_o        = ctrl_q[LAT-1][0];

endmodule

// File: tb/tb_ycbcr2rgb.sv
// tb/tb_ycbcr2rgb.sv - directed vector bench for ycbcr2rgb (expected values follow YCBCR2RGB_ROUND_EN)
module tb_ycbcr2rgb;

`ifdef YCBCR2RGB_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  localparam int KR = 91881;
  localparam int KGB = -22553;
  localparam int KGR = -46802;
  localparam int KB = 116130;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               coef_wr_i = 1'b0;
  logic signed [17:0] kr_cr_i = '0, kg_cb_i = '0, kg_cr_i = '0, kb_cb_i = '0;
  logic               coef_pend_o;
  logic               dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [7:0]         y_i = '0, cb_i = '0, cr_i = '0;
  logic               dv_o, hs_o, vs_o;
  logic [7:0]         r_o, g_o, b_o;

  int checks = 0;
  int failures = 0;

  ycbcr2rgb dut (
    .clk(clk), .rst(rst), .coef_wr_i(coef_wr_i),
    .kr_cr_i(kr_cr_i), .kg_cb_i(kg_cb_i), .kg_cr_i(kg_cr_i), .kb_cb_i(kb_cb_i),
    .coef_pend_o(coef_pend_o),
    .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .y_i(y_i), .cb_i(cb_i), .cr_i(cr_i),
    .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o)
  );

  typedef struct {
    int y, cb, cr, hs;
    int fr, fg, fb;
    int rr, rg, rb;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int kr, input int kgb, input int kgr, input int kb);
    kr_cr_i = 18'(kr);
    kg_cb_i = 18'(kgb);
    kg_cr_i = 18'(kgr);
    kb_cb_i = 18'(kb);
  endtask

  task automatic pixel(input int y, input int cb, input int cr);
    y_i  = 8'(y);
    cb_i = 8'(cb);
    cr_i = 8'(cr);
    dv_i = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          y    cb   cr  hs  floor(r,g,b)   round(r,g,b)
    vecs[0] = '{128, 128, 128, 0, 128, 128, 128, 128, 128, 128};
    vecs[1] = '{255, 128, 255, 1, 255, 164, 255, 255, 164, 255};
    vecs[2] = '{  0, 128,   0, 0,   0,  91,   0,   0,  91,   0};
    vecs[3] = '{100, 128, 130, 1, 102,  98, 100, 103,  99, 100};
    vecs[4] = '{  0,   0, 128, 1,   0,  44,   0,   0,  44,   0};
    vecs[5] = '{200, 255, 128, 0, 200, 156, 255, 200, 156, 255};
    vecs[6] = '{ 50, 100, 160, 0,  94,  36,   0,  95,  37,   0};
    vecs[7] = '{255, 255, 255, 1, 255, 120, 255, 255, 121, 255};

    // Reset state
    load(0, 0, 0, 0);
    repeat (3) tick();
    check("rst_dv_o", int'(dv_o), 0);
    check("rst_hs_o", int'(hs_o), 0);
    check("rst_vs_o", int'(vs_o), 0);
    check("rst_r_o", int'(r_o), 0);
    check("rst_g_o", int'(g_o), 0);
    check("rst_b_o", int'(b_o), 0);
    check("rst_pend", int'(coef_pend_o), 0);

    // Back-to-back vector stream with default coefficients
    rst = 1'b0;
    for (int i = 0; i < 8 + 3; i++) begin
      if (i < 8) begin
        pixel(vecs[i].y, vecs[i].cb, vecs[i].cr);
        hs_i = 1'(vecs[i].hs);
      end else begin
        dv_i = 1'b0;
        hs_i = 1'b0;
      end
      tick();
      if (i < 3) begin
        check($sformatf("lat_dv_o_%0d", i), int'(dv_o), 0);
      end else begin
        check($sformatf("vec%0d_dv_o", i - 3), int'(dv_o), 1);
        check($sformatf("vec%0d_hs_o", i - 3), int'(hs_o), vecs[i-3].hs);
        check($sformatf("vec%0d_r", i - 3), int'(r_o), RND ? vecs[i-3].rr : vecs[i-3].fr);
        check($sformatf("vec%0d_g", i - 3), int'(g_o), RND ? vecs[i-3].rg : vecs[i-3].fg);
        check($sformatf("vec%0d_b", i - 3), int'(b_o), RND ? vecs[i-3].rb : vecs[i-3].fb);
      end
    end
    dv_i = 1'b0;
    tick();

    // Mid-frame write of kr_cr=0: pending until vsync rises
    load(0, KGB, KGR, KB);
    coef_wr_i = 1'b1;
    tick();
    coef_wr_i = 1'b0;
    check("t4_pend_set", int'(coef_pend_o), 1);
    pixel(100, 128, 200);
    tick();
    dv_i = 1'b0;
    repeat (3) tick();
    check("t4_r_before_edge", int'(r_o), RND ? 201 : 200);
    check("t4_pend_hold", int'(coef_pend_o), 1);
    vs_i = 1'b1;
    pixel(100, 128, 200);
    tick();
    dv_i = 1'b0;
    check("t4_pend_clear", int'(coef_pend_o), 0);
    repeat (3) tick();
    check("t4_r_edge_pixel", int'(r_o), 100);
    check("t4_vs_o", int'(vs_o), 1);

    // Write coincident with the vsync edge: no transfer, newest shadow applies at next edge
    vs_i = 1'b0;
    load(KR, KGB, KGR, KB);
    coef_wr_i = 1'b1;
    tick();
    coef_wr_i = 1'b0;
    check("t5_pend_set", int'(coef_pend_o), 1);
    tick();
    vs_i = 1'b1;
    load(45940, KGB, KGR, KB);
    coef_wr_i = 1'b1;
    pixel(100, 128, 200);
    tick();
    coef_wr_i = 1'b0;
    dv_i = 1'b0;
    check("t5_pend_kept", int'(coef_pend_o), 1);
    repeat (3) tick();
    check("t5_r_old_set", int'(r_o), 100);
    vs_i = 1'b0;
    tick();
    vs_i = 1'b1;
    pixel(100, 128, 200);
    tick();
    dv_i = 1'b0;
    check("t5_pend_clear", int'(coef_pend_o), 0);
    repeat (3) tick();
    check("t5_r_new_set", int'(r_o), 150);

    // Reset mid-line with a pending write and a full control line
    hs_i = 1'b1;
    pixel(128, 128, 128);
    tick();
    load(0, 0, 0, 0);
    coef_wr_i = 1'b1;
    tick();
    coef_wr_i = 1'b0;
    repeat (2) tick();
    check("t6_pre_dv_o", int'(dv_o), 1);
    check("t6_pre_vs_o", int'(vs_o), 1);
    check("t6_pre_pend", int'(coef_pend_o), 1);
    rst = 1'b1;
    tick();
    check("t6_dv_o", int'(dv_o), 0);
    check("t6_hs_o", int'(hs_o), 0);
    check("t6_vs_o", int'(vs_o), 0);
    check("t6_r_o", int'(r_o), 0);
    check("t6_g_o", int'(g_o), 0);
    check("t6_b_o", int'(b_o), 0);
    check("t6_pend", int'(coef_pend_o), 0);
    rst = 1'b0;
    pixel(100, 128, 130);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_dv_o_flush%0d", i), int'(dv_o), 0);
    end
    tick();
    check("t6_dv_o_back", int'(dv_o), 1);
    check("t6_r_default", int'(r_o), RND ? 103 : 102);
    check("t6_g_default", int'(g_o), RND ? 99 : 98);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
